// File: rtl/pc_fetch_if.sv
// pc_fetch_if: fetch-unit bundle covering NextPClogic, instruction-memory and decode handshakes
interface pc_fetch_if #(parameter int CNT_W = 32);
  logic [63:0]      next_pc;
  logic             stall;
  logic [63:0]      current_pc;
  logic             imem_req_valid;
  logic             imem_req_ready;
  logic [63:0]      imem_req_addr;
  logic             imem_resp_valid;
  logic [31:0]      imem_resp_data;
  logic             instr_valid;
  logic [31:0]      instruction;
  logic [63:0]      instr_pc;
  logic             misaligned;
  logic [CNT_W-1:0] retired_count;
  modport master (
    input  next_pc, stall, imem_req_ready, imem_resp_valid, imem_resp_data,
    output current_pc, imem_req_valid, imem_req_addr, instr_valid, instruction, instr_pc,
           misaligned, retired_count
  );
  modport slave (
    output next_pc, stall, imem_req_ready, imem_resp_valid, imem_resp_data,
    input  current_pc, imem_req_valid, imem_req_addr, instr_valid, instruction, instr_pc,
           misaligned, retired_count
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register and fetch/issue sequencer; one request outstanding, sticky misalignment fault
module pc_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          CNT_W    = 32
) (
  input logic clk,
  input logic rst_n,
  pc_fetch_if.master bus
);
  typedef enum logic [1:0] {FETCH, WAIT, ISSUE, FAULT} state_t;
  state_t           state, state_n;
  logic [63:0]      pc;
  logic [31:0]      instr;
  logic [CNT_W-1:0] cnt;
  logic             commit;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      pc    <= RESET_PC;
      instr <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (state == WAIT && bus.imem_resp_valid) instr <= bus.imem_resp_data;
      if (commit) begin
        pc  <= bus.next_pc;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
  // request is held off while reset is asserted even though the state already reads FETCH
  always_comb begin
    state_n            = state;
    commit             = 1'b0;
    bus.imem_req_valid = 1'b0;
    bus.instr_valid    = 1'b0;
    bus.misaligned     = 1'b0;
    case (state)
      FETCH: begin
        bus.imem_req_valid = rst_n;
        state_n = bus.imem_req_ready ? WAIT : FETCH;
      end
      WAIT: state_n = bus.imem_resp_valid ? ISSUE : WAIT;
      ISSUE: begin
        bus.instr_valid = 1'b1;
        commit = !bus.stall;
        state_n = bus.stall ? ISSUE : bus.next_pc[1:0] == 2'b00 ? FETCH : FAULT;
      end
      default: bus.misaligned = 1'b1;
    endcase
  end
  assign bus.current_pc    = pc;
  assign bus.imem_req_addr = pc;
  assign bus.instr_pc      = pc;
  assign bus.instruction   = instr;
  assign bus.retired_count = cnt;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: randomized handshakes against a precomputed program trace and handshake rules
module tb_pc_fetch_unit;
  localparam logic [63:0] RESET_PC = 64'h0;
  localparam int N = 40;
  typedef struct {logic [63:0] pc; logic [31:0] ins; logic [31:0] cnt; logic [63:0] tgt;} issue_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  pc_fetch_if #(.CNT_W(32)) bus();
  pc_fetch_unit #(.RESET_PC(RESET_PC), .CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  issue_t      issue_q[$];
  logic [63:0] fetch_q[$];
  logic [63:0] tgt[N];
  int compared = 0;
  int mismatched = 0;
  bit mon_on = 1'b0;
  function automatic logic [31:0] mem(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_2468;
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic underflow(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: DUT presented output with no expected entry queued", name);
  endtask
  task automatic check_reset_values(input string tag);
    check({tag, "_req_valid"}, bus.imem_req_valid, 0);
    check({tag, "_instr_valid"}, bus.instr_valid, 0);
    check({tag, "_current_pc"}, bus.current_pc, RESET_PC);
    check({tag, "_instruction"}, bus.instruction, 0);
    check({tag, "_misaligned"}, bus.misaligned, 0);
    check({tag, "_retired"}, bus.retired_count, 0);
  endtask
  // Monitor: expectations come from the trace queues plus the handshake rules (fetch holds until
  // ready, WAIT lasts until a response, ISSUE holds while stalled, commit goes to fetch or fault).
  logic        exp_req = 1'b1, exp_iv = 1'b0, waiting = 1'b0, faulted = 1'b0;
  logic        nreq, niv, cm;
  logic [63:0] exp_cur = RESET_PC;
  issue_t      e;
  always @(negedge clk) if (mon_on) begin
    #1;
    cm = 1'b0;
    check("req_valid", bus.imem_req_valid, exp_req);
    check("instr_valid", bus.instr_valid, exp_iv);
    check("misaligned", bus.misaligned, faulted);
    check("current_pc", bus.current_pc, exp_cur);
    if (exp_req) begin
      if (fetch_q.size() == 0) underflow("fetch_q");
      else begin
        check("req_addr", bus.imem_req_addr, fetch_q[0]);
        if (bus.imem_req_ready) void'(fetch_q.pop_front());
      end
    end
    if (exp_iv) begin
      if (issue_q.size() == 0) underflow("issue_q");
      else begin
        check("instr_pc", bus.instr_pc, issue_q[0].pc);
        check("instruction", bus.instruction, issue_q[0].ins);
        check("retired_count", bus.retired_count, issue_q[0].cnt);
        if (!bus.stall) begin
          e = issue_q.pop_front();
          cm = 1'b1;
          exp_cur = e.tgt;
          faulted = e.tgt[1:0] != 2'b00;
        end
      end
    end
    nreq = (exp_req && !bus.imem_req_ready) || (cm && e.tgt[1:0] == 2'b00);
    niv = (waiting && bus.imem_resp_valid) || (exp_iv && bus.stall);
    waiting = (exp_req && bus.imem_req_ready) || (waiting && !bus.imem_resp_valid);
    exp_req = nreq;
    exp_iv = niv;
  end
  initial begin
    logic [63:0] p, t, paddr;
    int idx, cyc, delay;
    bit pending;
    // Program trace: sequential flow, a taken branch at 0x20, a wrap past 2^64, random jumps, then a fault.
    p = RESET_PC;
    for (int i = 0; i < N; i++) begin
      if (i == N - 1) t = (p + 64'h40) | 64'h2;
      else if (i == 8) t = 64'h100;
      else if (i == 9) t = 64'hFFFF_FFFF_FFFF_FFFC;
      else if (i >= 12 && $urandom_range(0, 4) == 0) t = {$urandom, $urandom} & ~64'h3;
      else t = p + 64'd4;
      fetch_q.push_back(p);
      issue_q.push_back('{p, mem(p), 32'(i), t});
      tgt[i] = t;
      p = t;
    end
    bus.next_pc = '0;
    bus.stall = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data = '0;
    #12;
    check_reset_values("reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    mon_on = 1'b1;
    idx = 0;
    cyc = 0;
    pending = 1'b0;
    delay = 0;
    paddr = '0;
    while (idx < N && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      bus.imem_req_ready = $urandom_range(0, 2) != 0;
      if (pending) begin
        bus.imem_resp_valid = delay == 0;
        bus.imem_resp_data = delay == 0 ? mem(paddr) : $urandom;
        if (delay == 0) pending = 1'b0;
        else delay--;
      end else begin
        bus.imem_resp_valid = $urandom_range(0, 5) == 0;
        bus.imem_resp_data = $urandom;
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        pending = 1'b1;
        paddr = bus.imem_req_addr;
        delay = $urandom_range(0, 2);
      end
      bus.next_pc = tgt[idx];
      bus.stall = $urandom_range(0, 2) == 0;
      if (bus.instr_valid && !bus.stall) idx++;
    end
    check("commits_before_timeout", idx, N);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.imem_req_ready = 1'b1;
      bus.imem_resp_valid = $urandom_range(0, 1) == 0;
      bus.stall = $urandom_range(0, 1) == 0;
      bus.next_pc = {$urandom, $urandom};
    end
    @(negedge clk);
    #3;
    mon_on = 1'b0;
    check("fault_retired", bus.retired_count, N);
    check("fault_pc", bus.current_pc, tgt[N-1]);
    check("fetch_q_left", fetch_q.size(), 0);
    check("issue_q_left", issue_q.size(), 0);
    // Reset out of FAULT, then again in the middle of WAIT with a late response arriving in FETCH.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.stall = 1'b0;
    #1;
    check_reset_values("fault_reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("r2_req_valid", bus.imem_req_valid, 1);
    check("r2_req_addr", bus.imem_req_addr, RESET_PC);
    @(negedge clk);
    #1;
    check("r2_wait_req_valid", bus.imem_req_valid, 0);
    rst_n = 1'b0;
    #1;
    check_reset_values("wait_reset");
    #1;
    rst_n = 1'b1;
    bus.imem_req_ready = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check("late_req_valid", bus.imem_req_valid, 1);
      check("late_req_addr", bus.imem_req_addr, RESET_PC);
      check("late_instr_valid", bus.instr_valid, 0);
      check("late_instruction", bus.instruction, 0);
      check("late_misaligned", bus.misaligned, 0);
    end
    bus.imem_req_ready = 1'b1;
    bus.imem_resp_valid = 1'b0;
    @(negedge clk);
    #1;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data = 32'h0BAD_F00D;
    @(negedge clk);
    #1;
    check("post_instr_valid", bus.instr_valid, 1);
    check("post_instruction", bus.instruction, 32'h0BAD_F00D);
    check("post_instr_pc", bus.instr_pc, RESET_PC);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
